mp_issuer: RTL
==============

# mp_issuer

Instruction issue unit for the `mp_top` micro-processor datapath. It packs opcode and register fields into 32-bit instruction words, stores a program of up to `DEPTH` words, and on `start` drives one instruction per clock onto `mp_top`'s instruction input. It retires each instruction by sampling the datapath result, and it tracks retired and invalid-opcode counts. It replaces hand-written instruction arrays in system benches and is the initiator side of the `mp_top` instruction interface.

## Interface
- `DEPTH`, 16: program memory depth in words.
- `AW`, 4: program address width; `DEPTH` = 2**`AW`.

- `clk`  in  1  rising-edge clock; shared with `mp_top`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  write one program word this cycle.
- `load_addr`  in  AW  program word address.
- `ld_opcode` / `ld_src1` / `ld_src2` / `ld_dst`  in  6/5/5/5  fields to pack.
- `load_err`  out  1  1-cycle pulse: load attempted while busy.
- `start`  in  1  begin issuing from address 0.
- `count`  in  AW+1  number of instructions to issue.
- `hold`  in  1  insert a bubble instead of advancing.
- `instruction`  out  32  to `mp_top.instruction`.
- `issue_valid`  out  1  `instruction` is a program word, not a bubble.
- `result_in`  in  32  from `mp_top.result`.
- `last_result`  out  32  result of most recently retired instruction.
- `retired_cnt`, `invalid_cnt`  out  AW+1 each  retired / invalid-opcode instructions.
- `busy`  out  1  state is ISSUE.
- `done`  out  1  1-cycle pulse at end of run.

## Operation
- **Packing**: word = {11'b0, dst, src2, src1, opcode}. The opcode occupies [5:0], src1 [10:6], src2 [15:11], dst [20:16].
- **Loading**: a load is accepted in IDLE or DONE and writes `mem[load_addr]` at the clock edge. A load while busy is dropped and pulses `load_err`. Program memory is not reset.
- **Valid opcodes**: {1,2,3,4,5,6,7,8,11,13,15}. Invalid opcodes are still issued; `mp_top` suppresses their write.
- **FSM states**: IDLE, ISSUE, DONE.
  - IDLE, `start`=1, `count`>0: go to ISSUE. Then `instruction`=`mem[0]`, `issue_valid`=1, `pc`=0, and both counters clear. A `count` greater than `DEPTH` is clamped to `DEPTH`.
  - IDLE, `start`=1, `count`=0: go to DONE. Counters clear and nothing is issued.
  - ISSUE, each edge while `issue_valid`=1: retire the current word.
    - `last_result` <= `result_in`.
    - `retired_cnt`++.
    - `invalid_cnt`++ if the opcode is invalid.
  - After a retire:
    - If `hold`=1, present a bubble.
    - Else if this was the last word, present a bubble and go to DONE.
    - Else present `mem[pc+1]` and increment `pc`.
  - ISSUE with a bubble presented (`issue_valid`=0):
    - If `hold`=0 and words remain, present `mem[pc]`.
    - If `hold`=0 and no words remain, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE and ISSUE.
- **Bubble**: `instruction`=0 (opcode 0 is invalid, so there is no register-file write) and `issue_valid`=0.
- **Counters**: width AW+1; they never wrap because the maximum value is `DEPTH`.

## Timing
- **Reset values**: all outputs are 0 and the state is IDLE. Reset mid-run aborts immediately; the in-flight instruction is not retired and `done` is not pulsed.
- **Outputs**: all are registered. Start-to-first-instruction latency is 1 cycle.
- **Retire point**: an instruction is retired at the same edge where `mp_top` commits its register write. The next word, presented after that edge, reads the updated register file, so back-to-back dependencies need no bubble.
- **Throughput**: `count` instructions with no hold complete in `count` cycles. `done` asserts one cycle after the final retire.
- **Hold**: `hold` never cancels the word on the bus, because that word retires at the edge regardless. Each held cycle adds exactly one bubble.
- **Load and start together** (both in IDLE): the load is written and the run starts. Address 0 reads the pre-write contents.

## Structure
- **Shared package `mp_pkg`**:
  - Field LSB/width constants.
  - Opcode constants.
  - `is_valid_opcode` function, also used by `mp_top`.
  - `pack_instr` function.
  - FSM state enum.
- **Sub-module**: `mp_prog_mem`, the DEPTH×32 program store with one synchronous write port and one asynchronous read port.

## Test plan
- **Encode**: load opcode=1, src1=2, src2=1, dst=0 at address 0 → `mem[0]` = 0x00000881. After a run of count=1 with `mp_top`: `last_result`=24486, `retired_cnt`=1, `done` pulses once.
- **Dependency**: [r0=r2+r1 (0x00000881), r31=r0−r3 (opcode 6, src1=0, src2=3, dst=31)], count=2 → results 24486 then 17416 on consecutive cycles, no bubble.
- **Invalid opcode**: opcode 9 word, count=1 → `invalid_cnt`=1, `last_result`=0, registers r0 and r31 unchanged.
- **Hold**: count=3 with `hold` high for 2 cycles after the first retire → 2 bubble cycles (`instruction`=0), all 3 retire, `done` at cycle 6 after start.
- **Edge cases**:
  - count=0 → `done` the next cycle, `retired_cnt`=0.
  - count=20 → clamped, `retired_cnt`=16.
  - Load during ISSUE → `load_err` pulse, memory unchanged.
- **Reset**: `rst_n` low mid-run → all outputs 0 asynchronously, no `done`. A new `start` reruns from address 0 with memory intact.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared definitions for the mp_top datapath and its instruction issuer.
// Contents: instruction field positions/widths, opcode constants, the
// valid-opcode decoder, the instruction packer and the issuer FSM state enum.
package mp_pkg;

  // Instruction field layout: {11'b0, dst, src2, src1, opcode}
  localparam int unsigned InstrW    = 32;
  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned OpcodeW   = 6;
  localparam int unsigned RegW      = 5;
  localparam int unsigned Src1Lsb   = 6;
  localparam int unsigned Src2Lsb   = 11;
  localparam int unsigned DstLsb    = 16;

  // Opcode 0 is the bubble encoding and is deliberately invalid.
  localparam logic [OpcodeW-1:0] OpNop = 6'd0;
  localparam logic [OpcodeW-1:0] OpAdd = 6'd1;
  localparam logic [OpcodeW-1:0] OpSub = 6'd6;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } mp_state_e;

  // Opcodes the datapath executes; anything else is issued but never writes back.
  function automatic logic is_valid_opcode(input logic [OpcodeW-1:0] op);
    logic valid;
    valid = 1'b0;
    case (op)
      6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd11, 6'd13, 6'd15: valid = 1'b1;
      default: valid = 1'b0;
    endcase
    return valid;
  endfunction

  function automatic logic [InstrW-1:0] pack_instr(input logic [OpcodeW-1:0] opcode,
                                                   input logic [RegW-1:0]    src1,
                                                   input logic [RegW-1:0]    src2,
                                                   input logic [RegW-1:0]    dst);
    return {11'b0, dst, src2, src1, opcode};
  endfunction

endpackage

// File: rtl/mp_prog_mem.sv
// Program store for mp_issuer: DEPTH x 32-bit words, one synchronous write
// port and one asynchronous read port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module mp_prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mp_issuer.sv
// Instruction issue unit for mp_top. Packs and stores a program, then on
// start drives one instruction per clock, retiring each word by sampling
// the datapath result at the same edge mp_top commits it.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   load_en/load_addr/ld_*           program load (accepted when not busy)
//   load_err                         pulse: load dropped because busy
//   start/count/hold                 run control
//   instruction/issue_valid          to mp_top (bubble = 0 / valid low)
//   result_in/last_result            datapath result in / last retired result
//   retired_cnt/invalid_cnt          run statistics
//   busy/done                        state ISSUE / 1-cycle end-of-run pulse
module mp_issuer
  import mp_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [5:0]    ld_opcode,
  input  logic [4:0]    ld_src1,
  input  logic [4:0]    ld_src2,
  input  logic [4:0]    ld_dst,
  output logic          load_err,
  input  logic          start,
  input  logic [AW:0]   count,
  input  logic          hold,
  output logic [31:0]   instruction,
  output logic          issue_valid,
  input  logic [31:0]   result_in,
  output logic [31:0]   last_result,
  output logic [AW:0]   retired_cnt,
  output logic [AW:0]   invalid_cnt,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] MaxCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] One      = (AW+1)'(1);

  mp_state_e   state_q, state_d;
  logic [AW:0] pc_q, pc_d;      // index of the word on the bus, or next to present
  logic [AW:0] num_q, num_d;    // clamped instruction count for this run
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] last_q, last_d;
  logic [AW:0] retired_q, retired_d;
  logic [AW:0] invalid_q, invalid_d;
  logic        load_err_q, load_err_d;

  logic          mem_we;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic [AW:0]   pc_next;

  assign mem_we  = load_en && (state_q != StIssue);
  assign pc_next = pc_q + One;

  mp_prog_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_prog_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(load_addr),
    .wdata(pack_instr(ld_opcode, ld_src1, ld_src2, ld_dst)),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  // Read address: word 0 when launching, the following word after a retire,
  // otherwise the pending word after a bubble. Loads land at the edge, so a
  // load coinciding with start still sees the old word 0.
  always_comb begin
    mem_raddr = pc_q[AW-1:0];
    if (state_q == StIdle) begin
      mem_raddr = '0;
    end else if (valid_q) begin
      mem_raddr = pc_next[AW-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    num_d      = num_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    last_d     = last_q;
    retired_d  = retired_q;
    invalid_d  = invalid_q;
    load_err_d = load_en && (state_q == StIssue);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          retired_d = '0;
          invalid_d = '0;
          if (count != '0) begin
            state_d = StIssue;
            num_d   = (count > MaxCount) ? MaxCount : count;
            pc_d    = '0;
            instr_d = mem_rdata;
            valid_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end

      StIssue: begin
        if (valid_q) begin
          // The word on the bus retires at this edge regardless of hold.
          last_d    = result_in;
          retired_d = retired_q + One;
          if (!is_valid_opcode(instr_q[5:0])) begin
            invalid_d = invalid_q + One;
          end
          pc_d = pc_next;
          if (hold || (pc_next == num_q)) begin
            instr_d = '0;
            valid_d = 1'b0;
            if (!hold) begin
              state_d = StDone;
            end
          end else begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
          end
        end else if (!hold) begin
          if (pc_q < num_q) begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      num_q      <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      last_q     <= '0;
      retired_q  <= '0;
      invalid_q  <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      num_q      <= num_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      retired_q  <= retired_d;
      invalid_q  <= invalid_d;
      load_err_q <= load_err_d;
    end
  end

  assign instruction = instr_q;
  assign issue_valid = valid_q;
  assign last_result = last_q;
  assign retired_cnt = retired_q;
  assign invalid_cnt = invalid_q;
  assign load_err    = load_err_q;
  assign busy        = (state_q == StIssue);
  assign done        = (state_q == StDone);

endmodule
